decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; opcode and format constants come from the shared package.
REQ-002 Clk  in  1  sole clock; all state updates on posedge.
REQ-003 Rst  in  1  synchronous, active-high reset.
REQ-004 InValid / InReady  in / out  1 / 1  upstream fetch handshake.
REQ-005 InInstr / InPC  in / in  32 / 32  instruction word and its PC.
REQ-006 AddrA / AddrB  out / out  5 / 5  register-file read addresses; combinational InInstr[19:15] / InInstr[24:20].
REQ-007 DataA / DataB  in / in  32 / 32  register-file read data; combinational return.
REQ-008 WbEn / WbAddr / WbData  in / in / in  1 / 5 / 32  copy of the register-file write port.
REQ-009 Flush  in  1  drop held and incoming instructions.
REQ-010 OutValid / OutReady  out / in  1 / 1  downstream execute handshake.
REQ-011 OutPC, OutRs1Val, OutRs2Val, OutImm  out  32 each  registered PC, operands, sign-extended immediate.
REQ-012 OutRd, OutOpcode, OutFunct3, OutFunct7b5  out  5, 7, 3, 1  registered decode fields.
REQ-013 OutRegWEn, OutIsLoad, OutIllegal  out  1 each  registered control flags.

Function
REQ-014 Storage is a single ID/EX register; OutValid marks it occupied.
REQ-015 Hazard = OutValid & OutIsLoad & OutRd!=0 & ((usesRs1 & rs1==OutRd) | (usesRs2 & rs2==OutRd)).
REQ-016 InReady = Flush | (~Hazard & (~OutValid | OutReady)); combinational, no state of its own.
REQ-017 Accept = InValid & InReady & ~Flush; on accept the register loads the decoded InInstr and OutValid=1 next cycle.
REQ-018 No accept, with OutValid & OutReady: OutValid=0 next cycle. This bubble case covers a Hazard stall: the load advances and the dependent instruction waits exactly one cycle.
REQ-019 Flush has top priority: OutValid=0 next cycle; any InValid word that cycle is consumed and discarded.
REQ-020 Output fields hold stable while OutValid & ~OutReady.
REQ-021 Decoding by opcode:
- LUI, AUIPC: U-type.
- JAL: J-type.
- JALR, LOAD, OP-IMM, SYSTEM, FENCE: I-type.
- STORE: S-type.
- BRANCH: B-type.
- OP: immediate is 0.
REQ-022 Immediates: sign-extended from bit 31; B/J bit 0 forced to 0; U low 12 bits 0.
REQ-023 Source-register use:
- usesRs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- usesRs2: BRANCH, STORE, OP.
REQ-024 OutRegWEn = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when rd!=0; otherwise 0.
REQ-025 OutIsLoad = 1 only for opcode 0000011.
REQ-026 Illegal instruction:
- Condition: unlisted opcode, or InInstr[1:0]!=2'b11.
- Effect: OutIllegal=1, OutRegWEn=0, OutIsLoad=0, OutImm=0.
- It still passes downstream.
REQ-027 rs1/rs2 == x0: captured operand is 0 regardless of DataA/DataB or bypass.

Reset
REQ-028 Rst=1 at a posedge clears OutValid and every Out* field to 0.
REQ-029 During reset: InReady reflects REQ-016 with OutValid=0; accepts are ignored.
REQ-030 Reset mid-stall discards the held instruction.
REQ-031 Rst has priority over Flush and accept.

Configuration
REQ-032 Macro DECODE_BYPASS_EN.
- Defined: on accept, if WbEn & WbAddr==rs & rs!=0, the operand captures WbData in place of DataA/DataB.
- Undefined: operands capture DataA/DataB only, and WbEn/WbAddr/WbData are unused.

Structure
REQ-033 Shared package rv32i_pkg holds the opcode localparams and the imm-format enum (NONE, I, S, B, U, J).
REQ-034 Sub-module imm_gen: combinational; inputs instruction and format; output the 32-bit immediate.

Verification
REQ-035 ADDI x5,x1,-1 (0xFFF08293), DataA=7 -> next cycle OutValid=1, OutRs1Val=7, OutImm=0xFFFFFFFF, OutRd=5, OutRegWEn=1.
REQ-036 LW x3,0(x2), then ADD x4,x3,x1 with OutReady=1:
- Cycle 2: InReady=0 and OutValid=1 holding the LW.
- Cycle 3: bubble, OutValid=0.
- Cycle 4: ADD accepted.
REQ-037 OutReady=0 for 3 cycles with OutValid=1 -> all Out* stable, InReady=0. Then OutReady=1 -> the next instruction loads.
REQ-038 Flush=1 with InValid=1 and OutValid=1 -> InReady=1, next cycle OutValid=0, the incoming word is lost.
REQ-039 Bypass case: DECODE_BYPASS_EN defined, WbEn=1, WbAddr=1, WbData=0xDEADBEEF, DataA=0, ADD x4,x1,x0 -> OutRs1Val=0xDEADBEEF, OutRs2Val=0. Without the macro -> OutRs1Val=0.
REQ-040 Instr 0x00000000 -> OutIllegal=1, OutRegWEn=0. Rst=1 mid-stream -> OutValid=0 next cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: major opcodes and the immediate-format enum
// used by decode_stage and imm_gen.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator. All formats sign-extend from
// instruction bit 31; B/J immediates have bit 0 forced to 0, U has its low
// 12 bits zero, and IMM_NONE yields 0.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  // The opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Reassemble the immediate bit fields for the selected format.
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a single ID/EX register and a valid/ready handshake
// on both sides. Stalls one cycle on a load-use dependency, drops work on
// Flush. Optional macro DECODE_BYPASS_EN forwards the register-file write
// port into the captured operands.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] InInstr,
  input  logic [31:0] InPC,
  output logic [4:0]  AddrA,
  output logic [4:0]  AddrB,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  input  logic        WbEn,
  input  logic [4:0]  WbAddr,
  input  logic [31:0] WbData,
  input  logic        Flush,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutPC,
  output logic [31:0] OutRs1Val,
  output logic [31:0] OutRs2Val,
  output logic [31:0] OutImm,
  output logic [4:0]  OutRd,
  output logic [6:0]  OutOpcode,
  output logic [2:0]  OutFunct3,
  output logic        OutFunct7b5,
  output logic        OutRegWEn,
  output logic        OutIsLoad,
  output logic        OutIllegal
);

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  imm_fmt_e    fmt;
  logic        legal, uses_rs1, uses_rs2, writes_rd;
  logic [31:0] imm_p0;
  logic [31:0] rs1_val_p0, rs2_val_p0;
  logic        hazard, accept;

  logic        vld_p1;
  logic [31:0] pc_p1, rs1_val_p1, rs2_val_p1, imm_p1;
  logic [4:0]  rd_p1;
  logic [6:0]  opcode_p1;
  logic [2:0]  funct3_p1;
  logic        funct7b5_p1, reg_wen_p1, is_load_p1, illegal_p1;

  // ---- Stage p0: combinational decode of the incoming word ----
  assign opcode = InInstr[6:0];
  assign rd     = InInstr[11:7];
  assign rs1    = InInstr[19:15];
  assign rs2    = InInstr[24:20];
  assign AddrA  = rs1;
  assign AddrB  = rs2;

  // Classify the opcode: immediate format, source usage, destination write.
  always_comb begin
    fmt       = IMM_NONE;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin fmt = IMM_U; writes_rd = 1'b1; end
      OPC_JAL:            begin fmt = IMM_J; writes_rd = 1'b1; end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        fmt = IMM_I; uses_rs1 = 1'b1; writes_rd = 1'b1;
      end
      OPC_SYSTEM, OPC_FENCE: fmt = IMM_I;
      OPC_STORE:  begin fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_BRANCH: begin fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      default:    legal = 1'b0;
    endcase
    // Compressed/odd encodings never match a listed opcode, but keep the
    // low-bit check explicit so the intent survives opcode-table edits.
    if (InInstr[1:0] != 2'b11) legal = 1'b0;
  end

  imm_gen u_imm_gen (
    .instr (InInstr),
    .fmt   (fmt),
    .imm   (imm_p0)
  );

`ifdef DECODE_BYPASS_EN
  // Operand capture with write-port forwarding; x0 always reads as zero.
  always_comb begin
    rs1_val_p0 = DataA;
    rs2_val_p0 = DataB;
    if (WbEn && WbAddr == rs1) rs1_val_p0 = WbData;
    if (WbEn && WbAddr == rs2) rs2_val_p0 = WbData;
    if (rs1 == 5'd0) rs1_val_p0 = '0;
    if (rs2 == 5'd0) rs2_val_p0 = '0;
  end
`else
  assign rs1_val_p0 = (rs1 == 5'd0) ? '0 : DataA;
  assign rs2_val_p0 = (rs2 == 5'd0) ? '0 : DataB;

  // The write-port copy only matters when forwarding is built in.
  logic unused_wb;
  assign unused_wb = ^{WbEn, WbAddr, WbData};
`endif

  // A load in ID/EX whose rd feeds this instruction forces one bubble.
  assign hazard = vld_p1 & is_load_p1 & (rd_p1 != 5'd0) &
                  ((uses_rs1 & (rs1 == rd_p1)) | (uses_rs2 & (rs2 == rd_p1)));
  assign InReady = Flush | (~hazard & (~vld_p1 | OutReady));
  assign accept  = InValid & InReady & ~Flush;

  // ---- Stage p1: ID/EX register ----
  // Reset beats flush beats accept; otherwise a consumed entry becomes a bubble.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_val_p1  <= '0;
      rs2_val_p1  <= '0;
      imm_p1      <= '0;
      rd_p1       <= '0;
      opcode_p1   <= '0;
      funct3_p1   <= '0;
      funct7b5_p1 <= 1'b0;
      reg_wen_p1  <= 1'b0;
      is_load_p1  <= 1'b0;
      illegal_p1  <= 1'b0;
    end else if (Flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      pc_p1       <= InPC;
      rs1_val_p1  <= rs1_val_p0;
      rs2_val_p1  <= rs2_val_p0;
      imm_p1      <= legal ? imm_p0 : '0;
      rd_p1       <= rd;
      opcode_p1   <= opcode;
      funct3_p1   <= InInstr[14:12];
      funct7b5_p1 <= InInstr[30];
      reg_wen_p1  <= legal & writes_rd & (rd != 5'd0);
      is_load_p1  <= legal & (opcode == OPC_LOAD);
      illegal_p1  <= ~legal;
    end else if (OutReady) begin
      vld_p1 <= 1'b0;
    end
  end

  assign OutValid    = vld_p1;
  assign OutPC       = pc_p1;
  assign OutRs1Val   = rs1_val_p1;
  assign OutRs2Val   = rs2_val_p1;
  assign OutImm      = imm_p1;
  assign OutRd       = rd_p1;
  assign OutOpcode   = opcode_p1;
  assign OutFunct3   = funct3_p1;
  assign OutFunct7b5 = funct7b5_p1;
  assign OutRegWEn   = reg_wen_p1;
  assign OutIsLoad   = is_load_p1;
  assign OutIllegal  = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, I/S/B/U/J/R decoding, load-use
// bubble, back-pressure hold, flush, operand bypass and illegal words.
module tb_decode_stage;

  logic        Clk = 1'b0;
  logic        Rst, InValid, InReady, Flush, OutValid, OutReady, WbEn;
  logic [31:0] InInstr, InPC, DataA, DataB, WbData;
  logic [4:0]  AddrA, AddrB, WbAddr, OutRd;
  logic [31:0] OutPC, OutRs1Val, OutRs2Val, OutImm;
  logic [6:0]  OutOpcode;
  logic [2:0]  OutFunct3;
  logic        OutFunct7b5, OutRegWEn, OutIsLoad, OutIllegal;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] I_ADDI = 32'hFFF08293; // addi x5,x1,-1
  localparam logic [31:0] I_LW   = 32'h00012183; // lw   x3,0(x2)
  localparam logic [31:0] I_ADD  = 32'h00118233; // add  x4,x3,x1
  localparam logic [31:0] I_SW   = 32'h00512423; // sw   x5,8(x2)
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3; // beq  x1,x2,-4
  localparam logic [31:0] I_LUI  = 32'h123453B7; // lui  x7,0x12345
  localparam logic [31:0] I_JAL  = 32'h008000EF; // jal  x1,+8
  localparam logic [31:0] I_ADDB = 32'h00008233; // add  x4,x1,x0

  always #5 Clk = ~Clk;

  decode_stage dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .InInstr(InInstr), .InPC(InPC), .AddrA(AddrA), .AddrB(AddrB),
    .DataA(DataA), .DataB(DataB), .WbEn(WbEn), .WbAddr(WbAddr),
    .WbData(WbData), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
    .OutPC(OutPC), .OutRs1Val(OutRs1Val), .OutRs2Val(OutRs2Val),
    .OutImm(OutImm), .OutRd(OutRd), .OutOpcode(OutOpcode),
    .OutFunct3(OutFunct3), .OutFunct7b5(OutFunct7b5), .OutRegWEn(OutRegWEn),
    .OutIsLoad(OutIsLoad), .OutIllegal(OutIllegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] da, input logic [31:0] db);
    InValid = 1'b1;
    InInstr = instr;
    InPC    = pc;
    DataA   = da;
    DataB   = db;
  endtask

  logic [31:0] exp_byp;

  initial begin
    Rst = 1'b1; InValid = 1'b0; InInstr = '0; InPC = '0; DataA = '0; DataB = '0;
    WbEn = 1'b0; WbAddr = '0; WbData = '0; Flush = 1'b0; OutReady = 1'b1;

    // Reset with an offered word: must not be accepted.
    present(I_ADDI, 32'h0000_0050, 32'd9, 32'd9);
    tick();
    tick();
    chk("rst_valid", OutValid, 0);
    chk("rst_pc", OutPC, 0);
    chk("rst_imm", OutImm, 0);
    chk("rst_rd", OutRd, 0);
    chk("rst_inready", InReady, 1);

    // ADDI x5,x1,-1
    Rst = 1'b0;
    present(I_ADDI, 32'h0000_0100, 32'd7, 32'h55);
    #1;
    chk("addi_addra", AddrA, 1);
    chk("addi_addrb", AddrB, 31);
    tick();
    chk("addi_valid", OutValid, 1);
    chk("addi_rs1", OutRs1Val, 7);
    chk("addi_imm", OutImm, 32'hFFFF_FFFF);
    chk("addi_rd", OutRd, 5);
    chk("addi_wen", OutRegWEn, 1);
    chk("addi_pc", OutPC, 32'h100);
    chk("addi_opc", OutOpcode, 7'h13);
    chk("addi_ill", OutIllegal, 0);

    // LW then dependent ADD: one-cycle bubble.
    present(I_LW, 32'h0000_0104, 32'h1000, 32'h0);
    tick();
    chk("lw_valid", OutValid, 1);
    chk("lw_isload", OutIsLoad, 1);
    chk("lw_rd", OutRd, 3);
    chk("lw_rs1", OutRs1Val, 32'h1000);
    chk("lw_f3", OutFunct3, 3'b010);
    present(I_ADD, 32'h0000_0108, 32'h11, 32'h22);
    #1;
    chk("haz_inready", InReady, 0);
    tick();
    chk("bubble_valid", OutValid, 0);
    chk("bubble_inready", InReady, 1);
    tick();
    chk("add_valid", OutValid, 1);
    chk("add_pc", OutPC, 32'h108);
    chk("add_rd", OutRd, 4);
    chk("add_rs1", OutRs1Val, 32'h11);
    chk("add_rs2", OutRs2Val, 32'h22);
    chk("add_imm", OutImm, 0);
    chk("add_isload", OutIsLoad, 0);

    // Back-pressure for 3 cycles: ADD held, SW waits.
    OutReady = 1'b0;
    present(I_SW, 32'h0000_010C, 32'h2000, 32'h77);
    #1;
    chk("stall_inready", InReady, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", OutValid, 1);
      chk("stall_pc", OutPC, 32'h108);
      chk("stall_rs1", OutRs1Val, 32'h11);
      chk("stall_rd", OutRd, 4);
      chk("stall_inready2", InReady, 0);
    end
    OutReady = 1'b1;
    #1;
    chk("release_inready", InReady, 1);
    tick();
    chk("sw_pc", OutPC, 32'h10C);
    chk("sw_imm", OutImm, 8);
    chk("sw_wen", OutRegWEn, 0);
    chk("sw_rs1", OutRs1Val, 32'h2000);
    chk("sw_rs2", OutRs2Val, 32'h77);
    chk("sw_opc", OutOpcode, 7'h23);

    // Flush with a held entry and an incoming word.
    OutReady = 1'b0;
    Flush = 1'b1;
    present(I_BEQ, 32'h0000_0110, 32'h0, 32'h0);
    #1;
    chk("flush_inready", InReady, 1);
    tick();
    chk("flush_valid", OutValid, 0);
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    tick();
    chk("flush_lost", OutValid, 0);

    // B / U / J immediates.
    present(I_BEQ, 32'h0000_0114, 32'h1, 32'h2);
    tick();
    chk("beq_imm", OutImm, 32'hFFFF_FFFC);
    chk("beq_wen", OutRegWEn, 0);
    present(I_LUI, 32'h0000_0118, 32'h0, 32'h0);
    tick();
    chk("lui_imm", OutImm, 32'h1234_5000);
    chk("lui_rd", OutRd, 7);
    chk("lui_wen", OutRegWEn, 1);
    present(I_JAL, 32'h0000_011C, 32'h0, 32'h0);
    tick();
    chk("jal_imm", OutImm, 8);
    chk("jal_wen", OutRegWEn, 1);

    // Write-port forwarding into rs1; rs2 = x0 stays zero.
`ifdef DECODE_BYPASS_EN
    exp_byp = 32'hDEAD_BEEF;
`else
    exp_byp = 32'h0;
`endif
    WbEn = 1'b1; WbAddr = 5'd1; WbData = 32'hDEAD_BEEF;
    present(I_ADDB, 32'h0000_0120, 32'h0, 32'h999);
    tick();
    chk("byp_rs1", OutRs1Val, exp_byp);
    chk("byp_rs2", OutRs2Val, 0);
    WbEn = 1'b0;

    // All-zero word is illegal but still flows.
    present(32'h0000_0000, 32'h0000_0124, 32'h5, 32'h6);
    tick();
    chk("ill_valid", OutValid, 1);
    chk("ill_flag", OutIllegal, 1);
    chk("ill_wen", OutRegWEn, 0);
    chk("ill_imm", OutImm, 0);

    // Reset while stalled discards the held instruction.
    present(I_ADDI, 32'h0000_0128, 32'd3, 32'd0);
    tick();
    chk("pre_rst_valid", OutValid, 1);
    OutReady = 1'b0;
    Rst = 1'b1;
    tick();
    chk("midrst_valid", OutValid, 0);
    chk("midrst_pc", OutPC, 0);
    chk("midrst_rs1", OutRs1Val, 0);
    Rst = 1'b0; InValid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
